// File: rtl/soc_system_sysid_pkg.sv
// Shared definitions for the sysid checker and the sysid slave generator:
// FSM state encoding, default build-time ID/timestamp words, timer width.
package soc_system_sysid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_ID = 3'd1,
      ST_WT_ID = 3'd2,
      ST_RD_TS = 3'd3,
      ST_WT_TS = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'hACD51302;
   localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h52D91E26;
   localparam int          TIMER_W             = 16;

endpackage

// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the sysid slave.
interface soc_system_sysid_checker_if;

   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );

endinterface

// File: rtl/soc_system_sysid_phase_timer.sv
// Per-phase watchdog: counts cycles spent in one bus phase and flags the
// last allowed cycle so the FSM can abort on the following edge.
module soc_system_sysid_phase_timer
   import soc_system_sysid_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TIMER_W-1:0] TC_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TIMER_W'(1);
      end
   end

   // count == TIMEOUT_CYCLES-1 marks the final cycle of the phase budget.
   assign tc = en && (count == TC_LAST);

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Reads sysid words 0 (ID) and 1 (timestamp), compares them with the
// build-time values and reports match / pass / timeout status.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RD_ID | read request for address 0 held until accepted
//   ST_WT_ID | waiting for ID readdatavalid
//   ST_RD_TS | read request for address 1 held until accepted
//   ST_WT_TS | waiting for timestamp readdatavalid
//   ST_DONE  | one-cycle done pulse; accepts a new start like IDLE
module soc_system_sysid_checker
   import soc_system_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   soc_system_sysid_checker_if.master  avm,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        id_ok,
   output logic                        ts_ok,
   output logic                        timeout,
   output logic [31:0]                 id_word,
   output logic [31:0]                 ts_word
);

   state_t state;
   logic   in_phase;
   logic   phase_exit;
   logic   tc;

   always_comb begin
      in_phase   = 1'b0;
      phase_exit = 1'b0;
      case (state)
         ST_RD_ID, ST_RD_TS: begin
            in_phase   = 1'b1;
            phase_exit = !avm.avm_waitrequest;
         end
         ST_WT_ID, ST_WT_TS: begin
            in_phase   = 1'b1;
            phase_exit = avm.avm_readdatavalid;
         end
         default: begin
            in_phase   = 1'b0;
            phase_exit = 1'b0;
         end
      endcase
   end

   // Clearing on any exit makes the count start from zero in every new state.
   soc_system_sysid_phase_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_phase_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (!in_phase || phase_exit || tc),
      .en      (in_phase),
      .tc      (tc)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         avm.avm_read    <= 1'b0;
         avm.avm_address <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         id_ok           <= 1'b0;
         ts_ok           <= 1'b0;
         timeout         <= 1'b0;
         id_word         <= '0;
         ts_word         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state           <= ST_RD_ID;
                  avm.avm_read    <= 1'b1;
                  avm.avm_address <= 1'b0;
                  busy            <= 1'b1;
                  pass            <= 1'b0;
                  id_ok           <= 1'b0;
                  ts_ok           <= 1'b0;
                  timeout         <= 1'b0;
                  id_word         <= '0;
                  ts_word         <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RD_ID, ST_RD_TS: begin
               if (!avm.avm_waitrequest) begin
                  state        <= (state == ST_RD_ID) ? ST_WT_ID : ST_WT_TS;
                  avm.avm_read <= 1'b0;
               end else if (tc) begin
                  state           <= ST_DONE;
                  avm.avm_read    <= 1'b0;
                  avm.avm_address <= 1'b0;
                  busy            <= 1'b0;
                  done            <= 1'b1;
                  timeout         <= 1'b1;
               end
            end
            ST_WT_ID: begin
               if (avm.avm_readdatavalid) begin
                  state           <= ST_RD_TS;
                  avm.avm_read    <= 1'b1;
                  avm.avm_address <= 1'b1;
                  id_word         <= avm.avm_readdata;
                  id_ok           <= (avm.avm_readdata == EXPECTED_ID);
               end else if (tc) begin
                  state   <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            ST_WT_TS: begin
               // A mismatch never aborts; pass just folds both compares together.
               if (avm.avm_readdatavalid) begin
                  state           <= ST_DONE;
                  avm.avm_address <= 1'b0;
                  busy            <= 1'b0;
                  done            <= 1'b1;
                  ts_word         <= avm.avm_readdata;
                  ts_ok           <= (avm.avm_readdata == EXPECTED_TS);
                  pass            <= id_ok && (avm.avm_readdata == EXPECTED_TS);
               end else if (tc) begin
                  state           <= ST_DONE;
                  avm.avm_address <= 1'b0;
                  busy            <= 1'b0;
                  done            <= 1'b1;
                  timeout         <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for the sysid checker with a configurable Avalon-MM slave
// model (wait states, response latency, dropped timestamp response).
module tb_soc_system_sysid_checker;

   localparam logic [31:0] ID_GOOD = 32'hACD51302;
   localparam logic [31:0] TS_GOOD = 32'h52D91E26;
   localparam logic [31:0] ID_BAD  = 32'hACD51303;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_word, ts_word;

   int checks = 0;
   int passed = 0;

   int          cfg_wait = 0;
   int          cfg_lat = 1;
   logic [31:0] cfg_id = ID_GOOD;
   logic [31:0] cfg_ts = TS_GOOD;
   bit          cfg_drop_ts = 1'b0;

   int          stall_cnt = 0;
   int          lat_left = 0;
   bit          pending = 1'b0;
   logic [31:0] pend_data = '0;

   soc_system_sysid_checker_if avm_bus ();

   soc_system_sysid_checker #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .avm     (avm_bus.master),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .id_ok   (id_ok),
      .ts_ok   (ts_ok),
      .timeout (timeout),
      .id_word (id_word),
      .ts_word (ts_word)
   );

   always #5 clock = ~clock;

   // Slave model: decides waitrequest mid-cycle from the registered request
   // and delivers readdatavalid cfg_lat cycles after acceptance.
   always @(negedge clock) begin
      avm_bus.avm_readdatavalid = 1'b0;
      if (pending) begin
         lat_left = lat_left - 1;
         if (lat_left <= 0) begin
            avm_bus.avm_readdatavalid = 1'b1;
            avm_bus.avm_readdata      = pend_data;
            pending                   = 1'b0;
         end
      end
      avm_bus.avm_waitrequest = 1'b0;
      if (!avm_bus.avm_read) begin
         stall_cnt = 0;
      end else if (stall_cnt < cfg_wait) begin
         avm_bus.avm_waitrequest = 1'b1;
         stall_cnt = stall_cnt + 1;
      end else begin
         stall_cnt = 0;
         if (!(avm_bus.avm_address && cfg_drop_ts)) begin
            pending   = 1'b1;
            lat_left  = cfg_lat;
            pend_data = avm_bus.avm_address ? cfg_ts : cfg_id;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg(input int w, input int l, input logic [31:0] id,
                      input logic [31:0] ts, input bit drop);
      cfg_wait    = w;
      cfg_lat     = l;
      cfg_id      = id;
      cfg_ts      = ts;
      cfg_drop_ts = drop;
   endtask

   // Pulses (or holds) start at relative cycle 0 and records observations.
   task automatic run_check(input bit hold, output int done_at, output int pulses,
                            output int stall_viol, output int rise1, output int rise2);
      logic prev_read, prev_addr;
      done_at = -1; pulses = 0; stall_viol = 0; rise1 = -1; rise2 = -1;
      prev_read = avm_bus.avm_read;
      prev_addr = avm_bus.avm_address;
      start = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (!hold) start = 1'b0;
         if (prev_read && avm_bus.avm_waitrequest &&
             (!avm_bus.avm_read || avm_bus.avm_address !== prev_addr))
            stall_viol++;
         if (avm_bus.avm_read && !prev_read) begin
            if (rise1 < 0) rise1 = i;
            else if (rise2 < 0) rise2 = i;
         end
         if (done === 1'b1) begin
            pulses++;
            if (done_at < 0) done_at = i;
         end
         prev_read = avm_bus.avm_read;
         prev_addr = avm_bus.avm_address;
         if (done_at >= 0 && (hold || i >= done_at + 3)) break;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      repeat (3) tick();
      checks++;
      if ({busy, done, pass, id_ok, ts_ok, timeout, avm_bus.avm_read, avm_bus.avm_address} !== 8'h00)
         $display("FAIL reset_flags: got %b want 00000000",
                  {busy, done, pass, id_ok, ts_ok, timeout, avm_bus.avm_read, avm_bus.avm_address});
      else passed++;
      checks++;
      if ({id_word, ts_word} !== 64'h0)
         $display("FAIL reset_words: got %h %h want 0 0", id_word, ts_word);
      else passed++;
      reset_n = 1'b1;
      repeat (2) tick();
      checks++;
      if ({busy, done, avm_bus.avm_read} !== 3'b000)
         $display("FAIL idle_after_reset: got %b want 000", {busy, done, avm_bus.avm_read});
      else passed++;
   endtask

   task automatic test_zero_wait();
      int d, p, sv, r1, r2;
      cfg(0, 1, ID_GOOD, TS_GOOD, 1'b0);
      run_check(1'b0, d, p, sv, r1, r2);
      checks++;
      if (d !== 5) $display("FAIL zw_done_at: got %0d want 5", d); else passed++;
      checks++;
      if (r1 !== 1 || r2 !== 3) $display("FAIL zw_read_cycles: got %0d,%0d want 1,3", r1, r2);
      else passed++;
      checks++;
      if ({pass, id_ok, ts_ok, timeout} !== 4'b1110)
         $display("FAIL zw_status: got %b want 1110", {pass, id_ok, ts_ok, timeout});
      else passed++;
      checks++;
      if (id_word !== ID_GOOD || ts_word !== TS_GOOD)
         $display("FAIL zw_words: got %h %h want %h %h", id_word, ts_word, ID_GOOD, TS_GOOD);
      else passed++;
      checks++;
      if (p !== 1 || busy !== 1'b0) $display("FAIL zw_done_pulse: got pulses %0d busy %b want 1 0", p, busy);
      else passed++;
   endtask

   task automatic test_id_mismatch();
      int d, p, sv, r1, r2;
      cfg(0, 1, ID_BAD, TS_GOOD, 1'b0);
      run_check(1'b0, d, p, sv, r1, r2);
      checks++;
      if (d !== 5) $display("FAIL mm_done_at: got %0d want 5", d); else passed++;
      checks++;
      if ({pass, id_ok, ts_ok, timeout} !== 4'b0010)
         $display("FAIL mm_status: got %b want 0010", {pass, id_ok, ts_ok, timeout});
      else passed++;
      checks++;
      if (id_word !== ID_BAD || ts_word !== TS_GOOD)
         $display("FAIL mm_words: got %h %h want %h %h", id_word, ts_word, ID_BAD, TS_GOOD);
      else passed++;
   endtask

   task automatic test_wait_states();
      int d, p, sv, r1, r2;
      cfg(3, 2, ID_GOOD, TS_GOOD, 1'b0);
      run_check(1'b0, d, p, sv, r1, r2);
      checks++;
      if (d !== 13) $display("FAIL ws_done_at: got %0d want 13", d); else passed++;
      checks++;
      if (sv !== 0) $display("FAIL ws_stall_stable: got %0d changes want 0", sv); else passed++;
      checks++;
      if (r1 !== 1 || r2 !== 7) $display("FAIL ws_read_cycles: got %0d,%0d want 1,7", r1, r2);
      else passed++;
      checks++;
      if ({pass, id_ok, ts_ok, timeout} !== 4'b1110)
         $display("FAIL ws_status: got %b want 1110", {pass, id_ok, ts_ok, timeout});
      else passed++;
   endtask

   task automatic test_timeout();
      int d, p, sv, r1, r2;
      cfg(0, 1, ID_GOOD, TS_GOOD, 1'b1);
      run_check(1'b0, d, p, sv, r1, r2);
      checks++;
      if (d !== 12) $display("FAIL to_resp_done_at: got %0d want 12", d); else passed++;
      checks++;
      if ({pass, id_ok, ts_ok, timeout} !== 4'b0101)
         $display("FAIL to_resp_status: got %b want 0101", {pass, id_ok, ts_ok, timeout});
      else passed++;
      checks++;
      if (id_word !== ID_GOOD || ts_word !== 32'h0)
         $display("FAIL to_resp_words: got %h %h want %h 0", id_word, ts_word, ID_GOOD);
      else passed++;
      checks++;
      if (p !== 1 || avm_bus.avm_read !== 1'b0)
         $display("FAIL to_resp_abort: got pulses %0d read %b want 1 0", p, avm_bus.avm_read);
      else passed++;
      // request phase never accepted
      cfg(100, 1, ID_GOOD, TS_GOOD, 1'b0);
      run_check(1'b0, d, p, sv, r1, r2);
      checks++;
      if (d !== 9) $display("FAIL to_req_done_at: got %0d want 9", d); else passed++;
      checks++;
      if ({pass, id_ok, ts_ok, timeout, avm_bus.avm_read} !== 5'b00010 || id_word !== 32'h0)
         $display("FAIL to_req_status: got %b id %h want 00010 0",
                  {pass, id_ok, ts_ok, timeout, avm_bus.avm_read}, id_word);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int d, p, sv, r1, r2;
      cfg(0, 3, ID_GOOD, TS_GOOD, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if ({busy, avm_bus.avm_read} !== 2'b10)
         $display("FAIL rm_in_wt_id: got %b want 10", {busy, avm_bus.avm_read});
      else passed++;
      reset_n = 1'b0;
      tick();
      checks++;
      if ({busy, done, pass, id_ok, ts_ok, timeout, avm_bus.avm_read} !== 7'h00)
         $display("FAIL rm_cleared: got %b want 0000000",
                  {busy, done, pass, id_ok, ts_ok, timeout, avm_bus.avm_read});
      else passed++;
      reset_n = 1'b1;
      repeat (2) tick();
      checks++;
      if ({busy, done, id_ok, avm_bus.avm_read} !== 4'b0000 || id_word !== 32'h0)
         $display("FAIL rm_late_rdv_ignored: got %b id %h want 0000 0",
                  {busy, done, id_ok, avm_bus.avm_read}, id_word);
      else passed++;
      cfg(0, 1, ID_GOOD, TS_GOOD, 1'b0);
      run_check(1'b0, d, p, sv, r1, r2);
      checks++;
      if (d !== 5 || pass !== 1'b1) $display("FAIL rm_recheck: got done_at %0d pass %b want 5 1", d, pass);
      else passed++;
   endtask

   task automatic test_start_held();
      int d, p, sv, r1, r2, n;
      cfg(0, 1, ID_GOOD, TS_GOOD, 1'b0);
      run_check(1'b1, d, p, sv, r1, r2);
      checks++;
      if (d !== 5 || pass !== 1'b1) $display("FAIL sh_first: got done_at %0d pass %b want 5 1", d, pass);
      else passed++;
      cfg_id = ID_BAD;
      tick();
      start = 1'b0;
      checks++;
      if ({avm_bus.avm_read, busy, pass, id_ok, ts_ok} !== 5'b11000 || id_word !== 32'h0)
         $display("FAIL sh_restart_cleared: got %b id %h want 11000 0",
                  {avm_bus.avm_read, busy, pass, id_ok, ts_ok}, id_word);
      else passed++;
      n = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (done === 1'b1) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n !== 4) $display("FAIL sh_second_done: got %0d want 4", n); else passed++;
      checks++;
      if ({pass, id_ok, ts_ok} !== 3'b001 || id_word !== ID_BAD)
         $display("FAIL sh_second_status: got %b id %h want 001 %h", {pass, id_ok, ts_ok}, id_word, ID_BAD);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_id_mismatch();
      test_wait_states();
      test_timeout();
      test_reset_mid();
      test_start_held();
      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
